rf_write_arbiter: RTL and testbench
===================================

# rf_write_arbiter

Shares the register file's single write port between the pipeline writeback stage and the multi-cycle multiply/divide unit (MDU). WB has fixed priority. MDU results wait in a 2-entry buffer until a free write cycle. A 31-bit pending scoreboard tells decode which registers still have MDU writes outstanding, so decode can stall on RAW/WAW hazards. The block sits between the WB/MDU stages and the register file write port, and beside the hazard unit.

## Interface
- STARVE_LIMIT, 4: consecutive cycles an MDU entry may be denied before WB is frozen.
- DATA_W, 32: write data width.
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  reset, asynchronous, active-high.
- wb_we, wb_waddr[4:0], wb_wdata[DATA_W-1:0]  in  WB write request; no backpressure except via stall_req.
- mdu_valid, mdu_waddr[4:0], mdu_wdata  in  MDU result handshake.
- mdu_ready  out  1  buffer can accept.
- issue_valid, issue_rd[4:0]  in  MDU op dispatched from decode.
- q_rs, q_rt, q_rd[4:0]  in  decode hazard queries.
- hz_rs, hz_rt, hz_rd  out  1 each  queried register has a pending MDU write.
- stall_req  out  1  freeze the pipeline, including WB, this cycle.
- rf_we, rf_waddr[4:0], rf_wdata  out  register-file write port, combinational. The RF samples it on negedge, half a cycle later.

## Operation
- A WB request exists when wb_we=1 and wb_waddr≠0. A WB write to $0 is not a request.
- An MDU push occurs when mdu_valid && mdu_ready.
  - mdu_ready = (count<2). It is registered-state only, with no combinational path from mdu_valid.
- Grant priority, evaluated each cycle:
  - stall_req=1: grant buffer head.
  - Else WB request present: grant WB.
  - Else buffer non-empty: grant buffer head.
  - Else a push this cycle: grant the incoming MDU write directly (zero-latency bypass). The entry still counts as accepted and is never stored.
  - Else: no grant.
- A granted MDU entry is popped. Push and pop may happen in the same cycle, and count stays unchanged.
- An MDU entry with waddr 0 is popped normally, but rf_we stays 0.
- Scoreboard:
  - A bit is set on issue_valid with issue_rd≠0.
  - The bit for an MDU write's address is cleared when that write is granted (buffered or bypass).
  - If set and clear hit the same register in the same cycle, set wins.
  - Decode guarantees at most one outstanding MDU write per register.
- hz_x = pending[q_x] for q_x≠0, else 0. This is combinational from registered state.
- rf_we/rf_waddr/rf_wdata come from the granted source. rf_we=0 when there is no grant or while reset is asserted.

## Timing
- Reset values:
  - Buffer empty, count=0.
  - pending=0, starve counter=0.
  - mdu_ready=1 after deassertion, 0 while reset is high.
  - stall_req=0, hz_*=0, rf_we=0.
- Reset mid-operation discards buffered entries and clears the scoreboard. Results lost this way are not recovered; the pipeline flushes on reset.
- Latency:
  - MDU write with an idle WB and empty buffer: same cycle.
  - Otherwise: the first cycle the write reaches the head and WB is idle (or the starve guard fires).
- The starve counter increments on each cycle the buffer is non-empty and WB is granted. It clears on any MDU grant.
- stall_req = (counter == STARVE_LIMIT), derived from the register. In that cycle:
  - The buffer head is written.
  - The counter clears at the next edge.
  - The pipeline re-presents the held WB write the next cycle.
- Count is 2 bits and never exceeds 2. The starve counter is $clog2(STARVE_LIMIT+1) bits and saturates at STARVE_LIMIT.

## Configuration
- RF_ARB_STARVE_EN defined: starvation counter and stall_req behave as above.
- Undefined: no counter. stall_req is tied 0. The MDU is granted only on WB-idle cycles, and the pipeline must guarantee idle slots.

## Structure
- Package rf_arb_pkg contains:
  - REG_W=5 and DATA_W default.
  - Typedef wr_req_t {we, waddr, wdata}.
  - Grant-source enum {GNT_NONE, GNT_WB, GNT_BUF, GNT_BYP}.
- Sub-module rf_arb_fifo: 2-entry wr_req_t FIFO with push/pop/count. The arbiter top holds the grant mux, scoreboard and starve counter.

## Test plan
- Reset, then MDU push {r8, 0x1234} with WB idle -> rf_we=1, rf_waddr=8 same cycle; mdu_ready stays 1; pending[8] clears.
- WB writes r3 every cycle; MDU pushes r9 and r10 -> mdu_ready=0 after two pushes; with STARVE_EN, stall_req=1 on the 5th cycle; r9 written, then r10 on the next stall or idle slot.
- issue_valid r5, q_rs=5 -> hz_rs=1 until the r5 MDU write is granted, then 0 the following cycle.
- Same cycle: issue r7 and MDU write to r7 granted -> pending[7] remains 1.
- MDU write to r0 and WB write to r0 -> rf_we=0; the MDU entry is popped and count decrements.
- Buffer holding two entries, pending bits set, reset pulse -> count=0, pending=0, rf_we=0, mdu_ready=1 after release.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write arbiter: widths, the buffered
// write request record, the grant-source encoding and a scoreboard lookup.
package rf_arb_pkg;

   localparam int REG_W  = 5;
   localparam int DATA_W = 32;

   typedef struct packed {
      logic              we;
      logic [REG_W-1:0]  waddr;
      logic [DATA_W-1:0] wdata;
   } wr_req_t;

   typedef enum logic [1:0] {
      GNT_NONE,
      GNT_WB,
      GNT_BUF,
      GNT_BYP
   } gnt_src_t;

   // Register 0 is never tracked, so a query for it never reports a hazard.
   function automatic logic pend_hit(input logic [31:1] pend, input logic [REG_W-1:0] r);
      logic hit;
      hit = 1'b0;
      if (r != '0) hit = pend[r];
      return hit;
   endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Signal bundle between the WB/MDU/decode side (master) and the register-file
// write arbiter (slave).
// Handshake: an MDU result transfers on a cycle where mdu_valid and mdu_ready
// are both high; mdu_ready depends only on registered buffer occupancy, and
// WB has no ready of its own -- it is held off only through stall_req.
interface rf_write_arbiter_if #(parameter int DATA_W = rf_arb_pkg::DATA_W) ();

   logic                          wb_we;
   logic [rf_arb_pkg::REG_W-1:0]  wb_waddr;
   logic [DATA_W-1:0]             wb_wdata;
   logic                          mdu_valid;
   logic [rf_arb_pkg::REG_W-1:0]  mdu_waddr;
   logic [DATA_W-1:0]             mdu_wdata;
   logic                          mdu_ready;
   logic                          issue_valid;
   logic [rf_arb_pkg::REG_W-1:0]  issue_rd;
   logic [rf_arb_pkg::REG_W-1:0]  q_rs;
   logic [rf_arb_pkg::REG_W-1:0]  q_rt;
   logic [rf_arb_pkg::REG_W-1:0]  q_rd;
   logic                          hz_rs;
   logic                          hz_rt;
   logic                          hz_rd;
   logic                          stall_req;
   logic                          rf_we;
   logic [rf_arb_pkg::REG_W-1:0]  rf_waddr;
   logic [DATA_W-1:0]             rf_wdata;

   modport master (
      output wb_we, wb_waddr, wb_wdata, mdu_valid, mdu_waddr, mdu_wdata,
             issue_valid, issue_rd, q_rs, q_rt, q_rd,
      input  mdu_ready, hz_rs, hz_rt, hz_rd, stall_req, rf_we, rf_waddr, rf_wdata
   );

   modport slave (
      input  wb_we, wb_waddr, wb_wdata, mdu_valid, mdu_waddr, mdu_wdata,
             issue_valid, issue_rd, q_rs, q_rt, q_rd,
      output mdu_ready, hz_rs, hz_rt, hz_rd, stall_req, rf_we, rf_waddr, rf_wdata
   );

endinterface

// File: rtl/rf_arb_fifo.sv
// Two-entry FIFO of MDU write requests. The caller never pushes when full
// nor pops when empty; push and pop in the same cycle keep count unchanged.
import rf_arb_pkg::*;

module rf_arb_fifo (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic       pop,
   input  wr_req_t    din,
   output wr_req_t    head,
   output logic [1:0] count
);

   wr_req_t mem [2];
   logic    wr_ptr;
   logic    rd_ptr;

   // Pointer and occupancy tracking; reset drops any buffered entries.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   // Entry storage needs no reset: count decides which entries are live.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB has fixed priority, MDU results wait
// in a 2-entry buffer (or bypass it when the port is free), and a pending
// scoreboard flags registers with outstanding MDU writes for decode.
// Build option RF_ARB_STARVE_EN: adds the starvation counter that raises
// stall_req after STARVE_LIMIT consecutive denied cycles; without it
// stall_req is tied low and STARVE_LIMIT does not exist.
import rf_arb_pkg::*;

module rf_write_arbiter #(
`ifdef RF_ARB_STARVE_EN
   parameter int STARVE_LIMIT = 4,
`endif
   parameter int DATA_W = rf_arb_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   rf_write_arbiter_if.slave bus
);

   wr_req_t           head;
   wr_req_t           fifo_din;
   logic [1:0]        count;
   logic              wb_req;
   logic              push;
   logic              pop;
   logic              fifo_push;
   logic              stall;
   gnt_src_t          gnt;
   logic              gnt_we;
   logic [REG_W-1:0]  gnt_addr;
   logic [DATA_W-1:0] gnt_data;
   logic [31:1]       pending;
   logic [31:1]       set_mask;
   logic [31:1]       clr_mask;

   assign wb_req        = bus.wb_we && (bus.wb_waddr != '0);
   assign bus.mdu_ready = !reset && (count != 2'd2);
   assign push          = bus.mdu_valid && bus.mdu_ready;

`ifdef RF_ARB_STARVE_EN
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   logic [SW-1:0] starve_cnt;

   assign stall = (starve_cnt == SW'(STARVE_LIMIT));

   // Count cycles the buffer head loses to WB; any MDU grant restarts it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         starve_cnt <= '0;
      else if (gnt == GNT_BUF || gnt == GNT_BYP)
         starve_cnt <= '0;
      else if (gnt == GNT_WB && count != 2'd0 && starve_cnt != SW'(STARVE_LIMIT))
         starve_cnt <= starve_cnt + 1'b1;
   end
`else
   assign stall = 1'b0;
`endif

   assign bus.stall_req = stall;

   // Grant priority: forced head write, then WB, then buffer, then bypass.
   always_comb begin
      gnt = GNT_NONE;
      if (reset)              gnt = GNT_NONE;
      else if (stall)         gnt = GNT_BUF;
      else if (wb_req)        gnt = GNT_WB;
      else if (count != 2'd0) gnt = GNT_BUF;
      else if (push)          gnt = GNT_BYP;
   end

   // Write-port mux from the granted source; $0 MDU writes are suppressed.
   always_comb begin
      gnt_we   = 1'b0;
      gnt_addr = '0;
      gnt_data = '0;
      case (gnt)
         GNT_WB: begin
            gnt_we   = 1'b1;
            gnt_addr = bus.wb_waddr;
            gnt_data = bus.wb_wdata;
         end
         GNT_BUF: begin
            gnt_we   = head.we;
            gnt_addr = head.waddr;
            gnt_data = head.wdata;
         end
         GNT_BYP: begin
            gnt_we   = (bus.mdu_waddr != '0);
            gnt_addr = bus.mdu_waddr;
            gnt_data = bus.mdu_wdata;
         end
         default: ;
      endcase
   end

   assign bus.rf_we    = gnt_we;
   assign bus.rf_waddr = gnt_addr;
   assign bus.rf_wdata = gnt_data;

   // A bypassed result is consumed immediately and never enters the buffer.
   assign pop       = (gnt == GNT_BUF);
   assign fifo_push = push && (gnt != GNT_BYP);
   assign fifo_din  = '{we: (bus.mdu_waddr != '0), waddr: bus.mdu_waddr, wdata: bus.mdu_wdata};

   rf_arb_fifo u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push),
      .pop   (pop),
      .din   (fifo_din),
      .head  (head),
      .count (count)
   );

   // Scoreboard set/clear masks for this cycle's issue and MDU grant.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (bus.issue_valid && bus.issue_rd != '0)
         set_mask[bus.issue_rd] = 1'b1;
      if ((gnt == GNT_BUF || gnt == GNT_BYP) && gnt_addr != '0)
         clr_mask[gnt_addr] = 1'b1;
   end

   // Pending update; set is applied after clear so a same-cycle set wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pending <= '0;
      else       pending <= (pending & ~clr_mask) | set_mask;
   end

   assign bus.hz_rs = pend_hit(pending, bus.q_rs);
   assign bus.hz_rt = pend_hit(pending, bus.q_rt);
   assign bus.hz_rd = pend_hit(pending, bus.q_rd);

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Bench for rf_write_arbiter: directed vectors with literal expectations plus
// a queue-based model compared against the outputs every cycle.
module tb_rf_write_arbiter;

`ifdef RF_ARB_STARVE_EN
   localparam int STARVE_EN = 1;
`else
   localparam int STARVE_EN = 0;
`endif
   localparam int STARVE_LIMIT = 4;

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_fail   = 0;

   rf_write_arbiter_if bus ();

   rf_write_arbiter dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- scoreboard model ----------------
   // Buffered MDU writes as {waddr, wdata}; pend[] is the set of registers
   // with outstanding MDU writes; starve counts denied head cycles.
   logic [36:0] exp_q[$];
   bit          pend[32];
   int          starve;

   always @(negedge clk) begin
      bit          e_ready, e_stall, wbr, pushed, mdu_gnt, was_nonempty;
      bit          e_we;
      logic [4:0]  e_addr;
      logic [31:0] e_data;
      int          src;   // 0 none, 1 wb, 2 buffer head, 3 bypass
      if (reset) begin
         exp_q.delete();
         foreach (pend[i]) pend[i] = 1'b0;
         starve = 0;
      end
      e_ready = !reset && (exp_q.size() < 2);
      e_stall = !reset && STARVE_EN != 0 && (starve >= STARVE_LIMIT);
      wbr     = bus.wb_we && bus.wb_waddr != 0;
      pushed  = bus.mdu_valid && e_ready;
      src = 0;
      if (!reset) begin
         if (e_stall)                src = 2;
         else if (wbr)               src = 1;
         else if (exp_q.size() != 0) src = 2;
         else if (pushed)            src = 3;
      end
      e_we = 1'b0; e_addr = '0; e_data = '0;
      if (src == 1) begin
         e_we = 1'b1; e_addr = bus.wb_waddr; e_data = bus.wb_wdata;
      end else if (src == 2) begin
         e_addr = exp_q[0][36:32]; e_data = exp_q[0][31:0]; e_we = (e_addr != 0);
      end else if (src == 3) begin
         e_addr = bus.mdu_waddr; e_data = bus.mdu_wdata; e_we = (e_addr != 0);
      end

      check("mdl_mdu_ready", bus.mdu_ready, e_ready);
      check("mdl_stall_req", bus.stall_req, e_stall);
      check("mdl_rf_we", bus.rf_we, e_we);
      if (e_we) begin
         check("mdl_rf_waddr", bus.rf_waddr, e_addr);
         check("mdl_rf_wdata", bus.rf_wdata, e_data);
      end
      check("mdl_hz_rs", bus.hz_rs, bus.q_rs != 0 && pend[bus.q_rs]);
      check("mdl_hz_rt", bus.hz_rt, bus.q_rt != 0 && pend[bus.q_rt]);
      check("mdl_hz_rd", bus.hz_rd, bus.q_rd != 0 && pend[bus.q_rd]);

      if (!reset) begin
         was_nonempty = (exp_q.size() != 0);
         mdu_gnt      = (src == 2 || src == 3);
         if (src == 2) void'(exp_q.pop_front());
         if (pushed && src != 3) exp_q.push_back({bus.mdu_waddr, bus.mdu_wdata});
         if (mdu_gnt && e_addr != 0) pend[e_addr] = 1'b0;
         if (bus.issue_valid && bus.issue_rd != 0) pend[bus.issue_rd] = 1'b1;
         if (mdu_gnt) starve = 0;
         else if (src == 1 && was_nonempty && starve < STARVE_LIMIT) starve++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.wb_we = 0; bus.wb_waddr = 0; bus.wb_wdata = 0;
      bus.mdu_valid = 0; bus.mdu_waddr = 0; bus.mdu_wdata = 0;
      bus.issue_valid = 0; bus.issue_rd = 0;
      bus.q_rs = 0; bus.q_rt = 0; bus.q_rd = 0;
   endtask

   task automatic wb(input logic [4:0] a, input logic [31:0] d);
      bus.wb_we = 1; bus.wb_waddr = a; bus.wb_wdata = d;
   endtask

   task automatic mdu(input logic [4:0] a, input logic [31:0] d);
      bus.mdu_valid = 1; bus.mdu_waddr = a; bus.mdu_wdata = d;
   endtask

   task automatic issue(input logic [4:0] r);
      bus.issue_valid = 1; bus.issue_rd = r;
   endtask

   // ---------------- directed stimulus ----------------
   int first_stall, t9, t10;

   initial begin
      idle();
      reset = 1'b1;
      @(negedge clk);
      check("rst_rf_we", bus.rf_we, 0);
      check("rst_mdu_ready", bus.mdu_ready, 0);
      check("rst_stall", bus.stall_req, 0);
      next();
      reset = 1'b0;
      @(negedge clk);
      check("rel_mdu_ready", bus.mdu_ready, 1);

      // Bypass: issue r8, then MDU r8 with WB idle writes in the same cycle.
      next(); issue(8);
      next(); idle(); bus.q_rs = 8;
      @(negedge clk);
      check("hz_r8_set", bus.hz_rs, 1);
      next(); mdu(8, 32'h1234);
      @(negedge clk);
      check("byp_rf_we", bus.rf_we, 1);
      check("byp_rf_waddr", bus.rf_waddr, 8);
      check("byp_rf_wdata", bus.rf_wdata, 32'h1234);
      check("byp_ready", bus.mdu_ready, 1);
      check("hz_r8_grant_cycle", bus.hz_rs, 1);
      next(); idle(); bus.q_rs = 8;
      @(negedge clk);
      check("hz_r8_cleared", bus.hz_rs, 0);
      check("byp_ready_after", bus.mdu_ready, 1);

      // Buffered r5: hazard holds until its grant, drops the cycle after.
      next(); idle(); issue(5);
      next(); idle(); bus.q_rs = 5; wb(3, 32'h5); mdu(5, 32'h55);
      @(negedge clk);
      check("hz_r5_buffered", bus.hz_rs, 1);
      next(); idle(); bus.q_rs = 5;
      @(negedge clk);
      check("r5_buf_grant", bus.rf_waddr, 5);
      check("hz_r5_grant_cycle", bus.hz_rs, 1);
      next(); idle(); bus.q_rs = 5;
      @(negedge clk);
      check("hz_r5_cleared", bus.hz_rs, 0);

      // WB writes r3 every cycle while MDU pushes r9 then r10.
      first_stall = -1; t9 = -1; t10 = -1;
      for (int i = 0; i < 18; i++) begin
         next(); idle();
         if (i < 14) wb(3, 32'h3333);
         if (i == 0) mdu(9, 32'h9999);
         if (i == 1) mdu(10, 32'haaaa);
         @(negedge clk);
         if (i == 2) check("ready_full", bus.mdu_ready, 0);
         if (bus.stall_req && first_stall < 0) first_stall = i;
         if (bus.rf_we && bus.rf_waddr == 9 && t9 < 0) t9 = i;
         if (bus.rf_we && bus.rf_waddr == 10 && t10 < 0) t10 = i;
      end
      check("first_stall_cycle", first_stall, STARVE_EN != 0 ? 5 : -1);
      check("r9_write_cycle", t9, STARVE_EN != 0 ? 5 : 14);
      check("r10_write_cycle", t10, STARVE_EN != 0 ? 10 : 15);

      // Same-cycle issue and bypass grant of r7: set wins.
      next(); idle(); issue(7); mdu(7, 32'h77);
      @(negedge clk);
      check("r7_byp_we", bus.rf_we, 1);
      next(); idle(); bus.q_rt = 7;
      @(negedge clk);
      check("hz_r7_set_wins", bus.hz_rt, 1);
      next(); idle(); bus.q_rt = 7; mdu(7, 32'h78);
      next(); idle(); bus.q_rt = 7;
      @(negedge clk);
      check("hz_r7_cleared", bus.hz_rt, 0);

      // $0 MDU entry buffered behind WB, then WB to $0: entry pops silently.
      next(); idle(); wb(3, 32'h1); mdu(0, 32'hdead);
      next(); idle(); wb(3, 32'h2); mdu(11, 32'hbbbb);
      next(); idle(); wb(0, 32'h3);
      @(negedge clk);
      check("r0_full_ready", bus.mdu_ready, 0);
      check("r0_rf_we", bus.rf_we, 0);
      next(); idle();
      @(negedge clk);
      check("r0_ready_after_pop", bus.mdu_ready, 1);
      check("r11_rf_waddr", bus.rf_waddr, 11);
      check("r11_rf_we", bus.rf_we, 1);

      // Reset with two buffered entries and pending bits set.
      next(); idle(); issue(12);
      next(); idle(); issue(13);
      next(); idle(); wb(3, 32'h4); mdu(12, 32'hc);
      next(); idle(); wb(3, 32'h5); mdu(13, 32'hd);
      next(); idle(); wb(3, 32'h6); bus.q_rs = 12; bus.q_rt = 13;
      @(negedge clk);
      check("pre_rst_ready", bus.mdu_ready, 0);
      check("pre_rst_hz12", bus.hz_rs, 1);
      check("pre_rst_hz13", bus.hz_rt, 1);
      next(); idle(); reset = 1'b1;
      @(negedge clk);
      check("mid_rst_rf_we", bus.rf_we, 0);
      check("mid_rst_ready", bus.mdu_ready, 0);
      next(); reset = 1'b0;
      @(negedge clk);
      check("post_rst_ready", bus.mdu_ready, 1);
      check("post_rst_rf_we", bus.rf_we, 0);
      for (int r = 1; r < 32; r++) begin
         next(); idle();
         bus.q_rs = 5'(r); bus.q_rt = 5'(r); bus.q_rd = 5'(r);
         @(negedge clk);
         check("post_rst_pending", {bus.hz_rs, bus.hz_rt, bus.hz_rd, bus.rf_we}, 0);
      end

      next(); idle();
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
